pdm_tx_cic: RTL and testbench

PDM transmit path for the I2S/PDM uDMA peripheral, the counterpart of the receive-side CIC decimator. It accepts signed PCM samples over a valid/ready handshake and upsamples them with a 2-stage CIC interpolator (differential delay 1, ratio R). A first-order sigma-delta modulator then turns the result into a 1-bit PDM stream, driven out with a generated PDM clock.

---
 rtl/pdm_tx_cic_if.sv | 11 +
 rtl/pdm_tx_cic.sv | 119 +++++++++++
 tb/tb_pdm_tx_cic.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_tx_cic_if.sv
// rtl/pdm_tx_cic_if.sv - PCM sample stream into the PDM transmit path
interface pdm_tx_cic_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pdm_tx_cic.sv
// rtl/pdm_tx_cic.sv - 2-stage CIC interpolator feeding a first-order sigma-delta PDM modulator
module pdm_tx_cic #(
    parameter int DATA_WIDTH = 16,
    parameter int RATE_WIDTH = 8,
    parameter int DIV_WIDTH  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    pdm_tx_cic_if.slave           sample,
    output logic                  pdm_clk_o,
    output logic                  pdm_data_o,
    output logic                  underrun_o
);
    localparam int W  = DATA_WIDTH + RATE_WIDTH + 2;
    localparam int AW = W + 2;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                state;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic                  pclk_q;
    logic [RATE_WIDTH-1:0] phase;
    logic                  buf_full;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [W-1:0]          x_d, c1_d, i1, i2;
    logic [AW-1:0]         acc;
    logic                  bit_q;
    logic                  underrun_q;

    logic                  div_tc, bit_tick, sample_tick, hs;
    logic [W-1:0]          x, c1, c2, u;
    logic [RATE_WIDTH:0]   ratio;
    logic [AW-1:0]         fb, acc_next;

    assign div_tc      = (div_cnt == clk_div_i);
    // A bit period ends on the terminal count that drives the PDM clock low.
    assign bit_tick    = en_i & div_tc & pclk_q;
    assign sample_tick = bit_tick & (phase == '0);
    assign hs          = sample.tvalid & ~buf_full & ~clr_i;

    assign x  = buf_full ? {{(W-DATA_WIDTH){buf_data[DATA_WIDTH-1]}}, buf_data} : '0;
    assign c1 = x - x_d;
    assign c2 = c1 - c1_d;
    assign u  = sample_tick ? c2 : '0;

    assign ratio    = {1'b0, rate_i} + (RATE_WIDTH+1)'(1);
    assign fb       = AW'(ratio) << (DATA_WIDTH-1);
    assign acc_next = acc + {{2{i2[W-1]}}, i2} - (bit_q ? fb : -fb);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            div_cnt    <= '0;
            pclk_q     <= 1'b0;
            phase      <= '0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            x_d        <= '0;
            c1_d       <= '0;
            i1         <= '0;
            i2         <= '0;
            acc        <= '0;
            bit_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else if (clr_i) begin
            state      <= en_i ? RUN : IDLE;
            div_cnt    <= '0;
            pclk_q     <= 1'b0;
            phase      <= '0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            x_d        <= '0;
            c1_d       <= '0;
            i1         <= '0;
            i2         <= '0;
            acc        <= '0;
            bit_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state      <= en_i ? RUN : IDLE;
            underrun_q <= sample_tick & ~buf_full;

            // A sample arriving on an underrunning tick is kept for the next one.
            if (hs) begin
                buf_full <= 1'b1;
                buf_data <= sample.tdata;
            end else if (sample_tick) begin
                buf_full <= 1'b0;
            end

            if (en_i) begin
                div_cnt <= div_tc ? '0 : div_cnt + DIV_WIDTH'(1);
                if (div_tc) pclk_q <= ~pclk_q;
            end

            if (sample_tick) begin
                x_d  <= x;
                c1_d <= c1;
            end

            if (bit_tick) begin
                phase <= (phase == rate_i) ? '0 : phase + RATE_WIDTH'(1);
                i1    <= i1 + u;
                i2    <= i2 + i1;
                acc   <= acc_next;
                bit_q <= ~acc_next[AW-1];
            end
        end
    end

    assign pdm_clk_o    = pclk_q & (state == RUN);
    assign pdm_data_o   = bit_q;
    assign underrun_o   = underrun_q;
    assign sample.tready = ~buf_full;
endmodule

// File: tb/tb_pdm_tx_cic.sv
// tb/tb_pdm_tx_cic.sv - directed bench for the PDM transmit CIC path
module tb_pdm_tx_cic;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] rate = '0;
    logic [9:0] clk_div = '0;
    logic       pdm_clk, pdm_data, underrun;

    int total = 0;
    int bad = 0;

    int bit_cnt = 0;
    int ones_cnt = 0;
    int ur_cnt = 0;
    int edge_viol = 0;
    logic prev_pclk = 1'b0;
    logic prev_data = 1'b0;

    pdm_tx_cic_if #(.DATA_WIDTH(16)) s_if ();

    pdm_tx_cic #(.DATA_WIDTH(16), .RATE_WIDTH(8), .DIV_WIDTH(10)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .clr_i      (clr),
        .rate_i     (rate),
        .clk_div_i  (clk_div),
        .sample     (s_if),
        .pdm_clk_o  (pdm_clk),
        .pdm_data_o (pdm_data),
        .underrun_o (underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prev_pclk && !pdm_clk) begin
            bit_cnt = bit_cnt + 1;
            if (pdm_data) ones_cnt = ones_cnt + 1;
        end else if (pdm_data !== prev_data) begin
            edge_viol = edge_viol + 1;
        end
        if (underrun) ur_cnt = ur_cnt + 1;
        prev_pclk = pdm_clk;
        prev_data = pdm_data;
    end

    task automatic wait_bits(input int n);
        int start;
        int cyc;
        start = bit_cnt;
        cyc = 0;
        while ((bit_cnt - start) < n && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 20000) begin
            total++; bad++;
            $display("FAIL wait_bits timeout got=%0d bits exp=%0d", bit_cnt - start, n);
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        en = 1'b0;
        clr = 1'b1;
        s_if.tvalid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (pdm_clk !== 1'b0) begin bad++; $display("FAIL reset_pdm_clk got=%b exp=0", pdm_clk); end
        total++; if (pdm_data !== 1'b0) begin bad++; $display("FAIL reset_pdm_data got=%b exp=0", pdm_data); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", s_if.tready); end
    endtask

    task automatic test_clock();
        int exp_clk [9] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};
        int viol0;
        viol0 = edge_viol;
        rate = 8'd0;
        clk_div = 10'd1;
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            total++;
            if (pdm_clk !== exp_clk[k][0]) begin
                bad++;
                $display("FAIL clk_wave[%0d] got=%b exp=%0d", k, pdm_clk, exp_clk[k]);
            end
        end
        wait_bits(8);
        total++;
        if (edge_viol != viol0) begin
            bad++;
            $display("FAIL data_edge got=%0d off-edge changes exp=0", edge_viol - viol0);
        end
    endtask

    task automatic run_steady(input string name, input logic [7:0] r, input logic [15:0] val,
                              input int exp_i2, input int lo, input int hi);
        int ones0, ur0, ones_d;
        do_clr();
        rate = r;
        clk_div = 10'd0;
        s_if.tdata = val;
        s_if.tvalid = 1'b1;
        en = 1'b1;
        wait_bits(32);
        total++;
        if ($signed(dut.i2) != exp_i2) begin
            bad++;
            $display("FAIL %s_i2 got=%0d exp=%0d", name, $signed(dut.i2), exp_i2);
        end
        ones0 = ones_cnt;
        ur0 = ur_cnt;
        wait_bits(256);
        ones_d = ones_cnt - ones0;
        total++;
        if (ones_d < lo || ones_d > hi) begin
            bad++;
            $display("FAIL %s_density got=%0d exp=%0d..%0d", name, ones_d, lo, hi);
        end
        total++;
        if (ur_cnt != ur0) begin
            bad++;
            $display("FAIL %s_no_underrun got=%0d exp=0", name, ur_cnt - ur0);
        end
    endtask

    task automatic test_underrun();
        int ur0, ones0, ones_d;
        s_if.tvalid = 1'b0;
        wait_bits(8);
        ur0 = ur_cnt;
        wait_bits(40);
        total++;
        if (ur_cnt - ur0 != 10) begin
            bad++;
            $display("FAIL underrun_rate got=%0d exp=10", ur_cnt - ur0);
        end
        wait_bits(64);
        ones0 = ones_cnt;
        wait_bits(256);
        ones_d = ones_cnt - ones0;
        total++;
        if (ones_d < 126 || ones_d > 130) begin
            bad++;
            $display("FAIL underrun_decay got=%0d exp=126..130", ones_d);
        end
    endtask

    task automatic test_clr();
        s_if.tdata = 16'd16384;
        s_if.tvalid = 1'b1;
        wait_bits(32);
        @(negedge clk);
        clr = 1'b1;
        s_if.tvalid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        total++; if (pdm_clk !== 1'b0) begin bad++; $display("FAIL clr_pdm_clk got=%b exp=0", pdm_clk); end
        total++; if (pdm_data !== 1'b0) begin bad++; $display("FAIL clr_pdm_data got=%b exp=0", pdm_data); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL clr_underrun got=%b exp=0", underrun); end
        total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL clr_ready got=%b exp=1", s_if.tready); end
        total++; if (dut.i2 != 0) begin bad++; $display("FAIL clr_i2 got=%0d exp=0", $signed(dut.i2)); end
        total++; if (dut.acc != 0) begin bad++; $display("FAIL clr_acc got=%0d exp=0", $signed(dut.acc)); end
    endtask

    task automatic test_async_rst();
        run_steady("pre_rst", 8'd3, 16'd16384, 65536, 190, 194);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (pdm_clk !== 1'b0) begin bad++; $display("FAIL rst_pdm_clk got=%b exp=0", pdm_clk); end
        total++; if (pdm_data !== 1'b0) begin bad++; $display("FAIL rst_pdm_data got=%b exp=0", pdm_data); end
        total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", s_if.tready); end
        total++; if (dut.i2 != 0) begin bad++; $display("FAIL rst_i2 got=%0d exp=0", $signed(dut.i2)); end
        s_if.tvalid = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exact_tick();
        do_clr();
        rate = 8'd3;
        clk_div = 10'd0;
        en = 1'b1;
        @(negedge clk);
        s_if.tdata = 16'd1000;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL exact_underrun got=%b exp=1", underrun); end
        total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL exact_held got=%b exp=0", s_if.tready); end
        repeat (7) @(negedge clk);
        total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL exact_still_held got=%b exp=0", s_if.tready); end
        @(negedge clk);
        total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL exact_consumed got=%b exp=1", s_if.tready); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL exact_no_underrun got=%b exp=0", underrun); end
        total++; if ($signed(dut.i1) != 1000) begin bad++; $display("FAIL exact_i1 got=%0d exp=1000", $signed(dut.i1)); end
    endtask

    initial begin
        test_reset();
        test_clock();
        run_steady("zero", 8'd3, 16'd0, 0, 126, 130);
        run_steady("neg", 8'd3, 16'hC000, -65536, 62, 66);
        run_steady("pos", 8'd3, 16'd16384, 65536, 190, 194);
        test_underrun();
        test_clr();
        run_steady("r1", 8'd0, 16'd16384, 16384, 190, 194);
        test_async_rst();
        test_exact_tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
